// File: rtl/xcore_muxn_arb.sv
// xcore_muxn_arb: N-channel DW-bit mux (static sel or round-robin) with valid/ready in, one registered out stage; ports clk, rst_n, in_data/in_valid/in_ready, rr_en, sel, out_data/out_valid/out_ch, out_ready
module xcore_muxn_arb #(
  parameter int NCH = 4,
  parameter int DW  = 8,
  localparam int SELW = $clog2(NCH)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NCH*DW-1:0]   in_data,
  input  logic [NCH-1:0]      in_valid,
  output logic [NCH-1:0]      in_ready,
  input  logic                rr_en,
  input  logic [SELW-1:0]     sel,
  output logic [DW-1:0]       out_data,
  output logic                out_valid,
  output logic [SELW-1:0]     out_ch,
  input  logic                out_ready
);
  logic [SELW-1:0] ptr, rr_g, g;
  logic            rr_hit, hit, load_en, take;
  always_comb begin
    rr_hit = 1'b0;
    rr_g   = '0;
    for (int i = NCH; i >= 1; i--) begin
      if (in_valid[SELW'((int'(ptr) + i) % NCH)]) begin
        rr_hit = 1'b1;
        rr_g   = SELW'((int'(ptr) + i) % NCH);
      end
    end
  end
  assign load_en  = !out_valid || out_ready;
  assign hit      = rr_en ? rr_hit : (int'(sel) < NCH);
  assign g        = rr_en ? rr_g : sel;
  assign in_ready = hit ? (NCH'(load_en) << g) : '0;
  assign take     = hit && load_en && in_valid[g];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
      ptr       <= SELW'(NCH - 1);
    end else begin
      if (take) begin
        out_data <= in_data[int'(g)*DW +: DW];
        out_ch   <= g;
        if (rr_en) ptr <= g;
      end
      if (load_en) out_valid <= take;
    end
  end
endmodule

// File: tb/tb_xcore_muxn_arb.sv
// tb_xcore_muxn_arb: table-driven vectors with a scoreboard queue of expected output words
module tb_xcore_muxn_arb;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] in_data;
  logic [3:0]  in_valid;
  logic [3:0]  in_ready;
  logic        rr_en;
  logic [1:0]  sel;
  logic [7:0]  out_data;
  logic        out_valid;
  logic [1:0]  out_ch;
  logic        out_ready;
  int checks = 0;
  int failures = 0;
  typedef struct {
    logic        rst;
    logic        rr;
    logic [1:0]  sel;
    logic [3:0]  iv;
    logic        ord;
    logic [31:0] dat;
    logic [3:0]  rdy;
  } vec_t;
  typedef struct {
    logic [7:0] d;
    logic [1:0] c;
  } word_t;
  vec_t  tbl[$];
  word_t q[$];
  word_t w;
  xcore_muxn_arb #(.NCH(4), .DW(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .rr_en(rr_en), .sel(sel), .out_data(out_data), .out_valid(out_valid), .out_ch(out_ch),
    .out_ready(out_ready)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  initial begin
    tbl = '{
      '{0,0,3,4'b1000,1,32'hA5000000,4'b1000},
      '{0,0,3,4'b1000,0,32'h3C000000,4'b0000},
      '{0,0,3,4'b1000,0,32'h3C000000,4'b0000},
      '{0,0,3,4'b1000,0,32'h3C000000,4'b0000},
      '{0,0,3,4'b1000,0,32'h3C000000,4'b0000},
      '{0,0,3,4'b1000,0,32'h3C000000,4'b0000},
      '{0,0,3,4'b1000,1,32'h3C000000,4'b1000},
      '{0,0,3,4'b0000,1,0,4'b1000},
      '{0,0,2,4'b1011,1,0,4'b0100},
      '{0,0,2,4'b1011,1,0,4'b0100},
      '{0,1,0,4'b1111,1,0,4'b0001},
      '{0,1,0,4'b1111,1,0,4'b0010},
      '{0,1,0,4'b1111,1,0,4'b0100},
      '{0,1,0,4'b1111,1,0,4'b1000},
      '{0,1,0,4'b1111,1,0,4'b0001},
      '{0,1,0,4'b1111,1,0,4'b0010},
      '{0,1,0,4'b1010,1,0,4'b1000},
      '{0,1,0,4'b1010,1,0,4'b0010},
      '{0,1,0,4'b1010,1,0,4'b1000},
      '{0,1,0,4'b1010,1,0,4'b0010},
      '{0,1,0,4'b1111,0,0,4'b0000},
      '{0,1,0,4'b1111,0,0,4'b0000},
      '{0,1,0,4'b1111,1,0,4'b0100},
      '{0,0,0,4'b0001,1,0,4'b0001},
      '{0,1,0,4'b1111,1,0,4'b1000},
      '{0,1,0,4'b0000,1,0,4'b0000},
      '{0,1,0,4'b0000,1,0,4'b0000},
      '{0,1,0,4'b1111,1,0,4'b0001},
      '{0,1,0,4'b1111,1,0,4'b0010},
      '{1,1,0,4'b1111,1,0,4'b0001},
      '{0,1,0,4'b1110,1,0,4'b0010},
      '{0,1,0,4'b0000,1,0,4'b0000},
      '{0,1,0,4'b0000,1,0,4'b0000}
    };
    rst_n = 1'b0;
    in_data = '0;
    in_valid = '0;
    rr_en = 1'b0;
    sel = '0;
    out_ready = 1'b0;
    #12;
    chk("reset_out_valid", int'(out_valid), 0);
    chk("reset_out_data", int'(out_data), 0);
    chk("reset_out_ch", int'(out_ch), 0);
    @(negedge clk);
    rst_n = 1'b1;
    foreach (tbl[i]) begin
      if (tbl[i].rst) begin
        #2 rst_n = 1'b0;
        #1;
        chk($sformatf("async_rst_valid[%0d]", i), int'(out_valid), 0);
        chk($sformatf("async_rst_data[%0d]", i), int'(out_data), 0);
        chk($sformatf("async_rst_ch[%0d]", i), int'(out_ch), 0);
        q.delete();
        @(negedge clk);
        rst_n = 1'b1;
      end
      rr_en = tbl[i].rr;
      sel = tbl[i].sel;
      in_valid = tbl[i].iv;
      out_ready = tbl[i].ord;
      for (int c = 0; c < 4; c++)
        in_data[c*8 +: 8] = (tbl[i].dat != 0) ? tbl[i].dat[c*8 +: 8] : 8'(i*4 + c + 1);
      #1;
      chk($sformatf("in_ready[%0d]", i), int'(in_ready), int'(tbl[i].rdy));
      chk($sformatf("out_valid[%0d]", i), int'(out_valid), int'(q.size() > 0));
      if (q.size() > 0) begin
        chk($sformatf("out_data[%0d]", i), int'(out_data), int'(q[0].d));
        chk($sformatf("out_ch[%0d]", i), int'(out_ch), int'(q[0].c));
        if (tbl[i].ord) void'(q.pop_front());
      end
      for (int c = 0; c < 4; c++)
        if (tbl[i].iv[c] && tbl[i].rdy[c]) begin
          w.d = in_data[c*8 +: 8];
          w.c = 2'(c);
          q.push_back(w);
        end
      @(negedge clk);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
